// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetch with a small in-order queue. Credits
// (queued + in-flight) bound outstanding requests to DEPTH. A redirect
// flushes the queue and marks responses still in flight as stale.
module instr_fetch_queue #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          DEPTH   = 2,
  parameter logic [1:0]  SZ_WORD = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_busy,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  mem_access_size,
  output logic        mem_rd_wr,
  output logic        mem_enable
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          q [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count, inflight, drop;
  logic [31:0]     fetch_pc, resp_pc;
  logic [CW:0]     used;
  logic            accept, push, pop;
  logic [31:0]     target;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign used            = {1'b0, count} + {1'b0, inflight};
  assign mem_req         = !reset && !redirect && (used < (CW+1)'(DEPTH));
  assign accept          = mem_req && !mem_busy;
  // Redirect wins over both queue ports; a response landing that cycle is stale.
  assign push            = mem_rvalid && (drop == '0) && !redirect;
  assign pop             = out_valid && out_ready && !redirect;
  assign target          = {redirect_pc[31:2], 2'b00};

  assign mem_addr        = fetch_pc;
  assign mem_access_size = SZ_WORD;
  assign mem_rd_wr       = 1'b1;
  assign mem_enable      = ~reset;

  // Head presentation; zero when empty so reset/flush show clean outputs.
  always_comb begin
    out_valid = (count != '0);
    out_instr = '0;
    out_pc    = '0;
    if (out_valid) begin
      out_instr = q[head].instr;
      out_pc    = q[head].pc;
    end
  end

  // Queue storage: data only, validity lives in count.
  always_ff @(posedge clk) begin
    if (push) q[tail] <= '{pc: resp_pc, instr: mem_rdata};
  end

  // Fetch PC, credit counters, queue pointers and redirect handling.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= PC_INIT;
      resp_pc  <= PC_INIT;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= inflight + CW'(accept) - CW'(mem_rvalid);
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      if (redirect) begin
        fetch_pc <= target;
        resp_pc  <= target;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
        drop     <= drop + inflight - CW'(mem_rvalid);
      end else begin
        if (mem_rvalid && (drop != '0)) drop <= drop - 1'b1;
        if (push) begin
          tail    <= nxt(tail);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) head <= nxt(head);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench: per-cycle vector table plus hand sequences for redirect
// and reset corner cases. A one-cycle-latency memory model answers requests.
module tb_instr_fetch_queue;

  localparam int DEPTH = 2;

  logic        clk, reset, redirect, out_ready, mem_busy, mem_rvalid;
  logic [31:0] redirect_pc, mem_rdata;
  logic        out_valid, mem_req, mem_rd_wr, mem_enable;
  logic [31:0] out_instr, out_pc, mem_addr;
  logic [1:0]  mem_access_size;

  int total = 0;
  int bad   = 0;

  instr_fetch_queue #(.PC_INIT(32'h0), .DEPTH(DEPTH), .SZ_WORD(2'b01)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_busy(mem_busy), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_access_size(mem_access_size), .mem_rd_wr(mem_rd_wr),
    .mem_enable(mem_enable)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] img(input logic [31:0] a);
    return a ^ 32'h8C00_1234;
  endfunction

  typedef struct {
    logic        rst;   // reset before this row
    logic        rdy, busy, redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        ov;
    logic [31:0] pc;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(logic rst, logic rdy, logic busy, logic redir,
                              logic [31:0] rpc, logic req, logic [31:0] addr,
                              logic ov, logic [31:0] pc);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.busy = busy; r.redir = redir; r.rpc = rpc;
    r.req = req; r.addr = addr; r.ov = ov; r.pc = pc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; memory answers an accepted request one cycle later.
  task automatic tick();
    logic acc;
    logic [31:0] a;
    acc = mem_req && !mem_busy;
    a   = mem_addr;
    @(posedge clk);
    #1;
    mem_rvalid = acc;
    mem_rdata  = acc ? img(a) : 32'h0;
  endtask

  task automatic do_reset();
    reset = 1; redirect = 0; out_ready = 1; mem_busy = 0; redirect_pc = 0;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic cyc(input string tag, input logic rdy, input logic busy,
                     input logic redir, input logic [31:0] rpc,
                     input logic ereq, input logic [31:0] eaddr,
                     input logic eov, input logic [31:0] epc);
    out_ready = rdy; mem_busy = busy; redirect = redir; redirect_pc = rpc;
    #1;
    chk({tag, ".req"},   32'(mem_req),   32'(ereq));
    chk({tag, ".addr"},  mem_addr,       eaddr);
    chk({tag, ".valid"}, 32'(out_valid), 32'(eov));
    chk({tag, ".pc"},    out_pc,         epc);
    chk({tag, ".instr"}, out_instr,      eov ? img(epc) : 32'h0);
    tick();
  endtask

  // Protocol invariants sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (!reset && mem_rvalid && dut.inflight == 0) begin
      bad++;
      $display("FAIL rvalid_without_inflight: inflight=%0d", dut.inflight);
    end
    if (!reset && !redirect && mem_rvalid && dut.drop == 0 && dut.count == DEPTH) begin
      bad++;
      $display("FAIL push_when_full: count=%0d", dut.count);
    end
  end

  initial begin
    reset = 1; redirect = 0; redirect_pc = 0; out_ready = 1; mem_busy = 0;
    mem_rvalid = 0; mem_rdata = 0;
    tick();
    tick();
    #1;
    chk("rst.valid",  32'(out_valid),       32'd0);
    chk("rst.req",    32'(mem_req),         32'd0);
    chk("rst.addr",   mem_addr,             32'h0);
    chk("rst.pc",     out_pc,               32'h0);
    chk("rst.instr",  out_instr,            32'h0);
    chk("rst.enable", 32'(mem_enable),      32'd0);
    chk("rst.size",   32'(mem_access_size), 32'd1);
    chk("rst.rdwr",   32'(mem_rd_wr),       32'd1);

    // Test 1: streaming from PC_INIT, out_ready high.
    v.push_back(mk(1, 1, 0, 0, 0, 1, 32'h00, 0, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 32'h04, 0, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 32'h08, 1, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 32'h08, 1, 32'h4));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 32'h0C, 0, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 32'h10, 1, 32'h8));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 32'h10, 1, 32'hC));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 32'h14, 0, 32'h0));
    // Test 2: backpressure for 10 cycles, then release.
    v.push_back(mk(1, 0, 0, 0, 0, 1, 32'h00, 0, 32'h0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 32'h04, 0, 32'h0));
    for (int i = 0; i < 8; i++) v.push_back(mk(0, 0, 0, 0, 0, 0, 32'h08, 1, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 32'h08, 1, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 32'h08, 1, 32'h4));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 32'h0C, 0, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 32'h10, 1, 32'h8));
    // Test 3: memory busy for 3 cycles while 0x8 is requested.
    v.push_back(mk(1, 1, 0, 0, 0, 1, 32'h00, 0, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 32'h04, 0, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 32'h08, 1, 32'h0));
    v.push_back(mk(0, 1, 1, 0, 0, 1, 32'h08, 1, 32'h4));
    v.push_back(mk(0, 1, 1, 0, 0, 1, 32'h08, 0, 32'h0));
    v.push_back(mk(0, 1, 1, 0, 0, 1, 32'h08, 0, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 32'h08, 0, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 32'h0C, 0, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 32'h10, 1, 32'h8));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 32'h10, 1, 32'hC));
    // Test 4: redirect to 0x40 with 0x8 queued and 0xC arriving.
    v.push_back(mk(1, 1, 0, 0, 0, 1, 32'h00, 0, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 32'h04, 0, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 32'h08, 1, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 32'h08, 1, 32'h4));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 32'h0C, 0, 32'h0));
    v.push_back(mk(0, 1, 0, 1, 32'h40, 0, 32'h10, 1, 32'h8));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 32'h40, 0, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 32'h44, 0, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 32'h48, 1, 32'h40));
    v.push_back(mk(0, 1, 0, 0, 0, 1, 32'h48, 1, 32'h44));

    foreach (v[i]) begin
      if (v[i].rst) do_reset();
      cyc($sformatf("vec%0d", i), v[i].rdy, v[i].busy, v[i].redir, v[i].rpc,
          v[i].req, v[i].addr, v[i].ov, v[i].pc);
    end

    // Test 5: unaligned redirect coinciding with a response and a pop.
    do_reset();
    cyc("t5.c0", 1, 0, 0, 0,        1, 32'h00, 0, 32'h0);
    cyc("t5.c1", 1, 0, 0, 0,        1, 32'h04, 0, 32'h0);
    cyc("t5.c2", 1, 0, 1, 32'h43,   0, 32'h08, 1, 32'h0);
    cyc("t5.c3", 1, 0, 0, 0,        1, 32'h40, 0, 32'h0);
    cyc("t5.c4", 1, 0, 0, 0,        1, 32'h44, 0, 32'h0);
    cyc("t5.c5", 1, 0, 0, 0,        0, 32'h48, 1, 32'h40);

    // Test 6: reset with entries queued and a response in flight.
    do_reset();
    cyc("t6.c0", 0, 0, 0, 0, 1, 32'h00, 0, 32'h0);
    cyc("t6.c1", 0, 0, 0, 0, 1, 32'h04, 0, 32'h0);
    reset = 1;
    tick();
    #1;
    chk("t6.rst.valid", 32'(out_valid), 32'd0);
    chk("t6.rst.req",   32'(mem_req),   32'd0);
    chk("t6.rst.addr",  mem_addr,       32'h0);
    tick();
    reset = 0;
    cyc("t6.c2", 1, 0, 0, 0, 1, 32'h00, 0, 32'h0);
    cyc("t6.c3", 1, 0, 0, 0, 1, 32'h04, 0, 32'h0);
    cyc("t6.c4", 1, 0, 0, 0, 0, 32'h08, 1, 32'h0);
    cyc("t6.c5", 1, 0, 0, 0, 1, 32'h08, 1, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
